// File: rtl/elapsed_ms_pkg.sv
// Shared millisecond-timing definitions used by the stopwatch and the delay generator.
package elapsed_ms_pkg;

  localparam int unsigned PER_MS_DEFAULT = 50_000;
  localparam int unsigned MS_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_t;

endpackage

// File: rtl/elapsed_ms_if.sv
// Control and result signals of the millisecond stopwatch.
interface elapsed_ms_if
  import elapsed_ms_pkg::*;
();

  logic            start;
  logic            stop;
  logic            busy;
  logic            done;
  logic            overflow;
  logic [MS_W-1:0] elapsed_ms;
  logic [MS_W-1:0] live_ms;

  modport master (
    output start, stop,
    input  busy, done, overflow, elapsed_ms, live_ms
  );

  modport slave (
    input  start, stop,
    output busy, done, overflow, elapsed_ms, live_ms
  );

endinterface

// File: rtl/elapsed_ms_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every PER_MS_COUNTER_VALUE enabled cycles.
module ms_tick_gen #(
  parameter int unsigned PER_MS_COUNTER_VALUE = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = $clog2(PER_MS_COUNTER_VALUE);
  localparam logic [W-1:0] LAST = W'(PER_MS_COUNTER_VALUE - 1);

  logic [W-1:0] sub_cnt;

  assign tick = en && (sub_cnt == LAST);

  // clr dominates en so a restart realigns the phase on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt <= '0;
    end else if (clr) begin
      sub_cnt <= '0;
    end else if (en) begin
      if (tick) sub_cnt <= '0;
      else      sub_cnt <= sub_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/elapsed_ms.sv
// Millisecond stopwatch: measures start-edge to stop-edge interval in whole ms.
module elapsed_ms
  import elapsed_ms_pkg::*;
#(
  parameter int unsigned PER_MS_COUNTER_VALUE = PER_MS_DEFAULT
) (
  input logic         clk,
  input logic         rst_n,
  elapsed_ms_if.slave bus
);

  state_t          state, state_nx;
  logic            start_q, stop_q;
  logic            start_edge, stop_edge;
  logic            tick, clr;
  logic            done_r, done_nx;
  logic            ovf_r, ovf_nx, ovf_tick;
  logic [MS_W-1:0] live_r, live_nx, live_tick;
  logic [MS_W-1:0] elapsed_r, elapsed_nx;

  assign start_edge = bus.start & ~start_q;
  assign stop_edge  = bus.stop  & ~stop_q;

  ms_tick_gen #(
    .PER_MS_COUNTER_VALUE(PER_MS_COUNTER_VALUE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (state == ST_RUN),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      start_q   <= 1'b1;
      stop_q    <= 1'b1;
      done_r    <= 1'b0;
      ovf_r     <= 1'b0;
      live_r    <= '0;
      elapsed_r <= '0;
    end else begin
      state     <= state_nx;
      start_q   <= bus.start;
      stop_q    <= bus.stop;
      done_r    <= done_nx;
      ovf_r     <= ovf_nx;
      live_r    <= live_nx;
      elapsed_r <= elapsed_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    done_nx    = 1'b0;
    clr        = 1'b0;
    ovf_nx     = ovf_r;
    live_nx    = live_r;
    elapsed_nx = elapsed_r;
    live_tick  = live_r;
    ovf_tick   = ovf_r;

    // saturating count; a tick at the ceiling only flags overflow
    if (tick) begin
      if (live_r == '1) ovf_tick  = 1'b1;
      else              live_tick = live_r + 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          clr      = 1'b1;
          live_nx  = '0;
          ovf_nx   = 1'b0;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        live_nx = live_tick;
        ovf_nx  = ovf_tick;
        if (stop_edge) begin
          elapsed_nx = live_tick;
          done_nx    = 1'b1;
          state_nx   = ST_IDLE;
        end else if (start_edge) begin
          clr     = 1'b1;
          live_nx = '0;
          ovf_nx  = 1'b0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.busy       = (state == ST_RUN);
  assign bus.done       = done_r;
  assign bus.overflow   = ovf_r;
  assign bus.live_ms    = live_r;
  assign bus.elapsed_ms = elapsed_r;

endmodule

// File: tb/tb_elapsed_ms.sv
// Randomized and directed bench for elapsed_ms against a time-stamp reference model.
module tb_elapsed_ms;

  localparam int unsigned P = 4;

  logic clk = 1'b0;
  logic rst_n;

  elapsed_ms_if bus ();

  elapsed_ms #(
    .PER_MS_COUNTER_VALUE(P)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: remembers when the measurement began and derives counts by division.
  longint cyc = 0;
  longint m_t0 = 0;
  bit     m_run, m_done, m_ovf, m_prev_s, m_prev_p;
  longint m_live, m_elapsed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  function automatic longint ms_at(input longint c);
    longint q;
    q = (c - m_t0) / P;
    return (q > 65535) ? 65535 : q;
  endfunction

  function automatic bit over_at(input longint c);
    return ((c - m_t0) / P) > 65535;
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_ovf = 0;
    m_live = 0; m_elapsed = 0;
    m_prev_s = 1; m_prev_p = 1;
  endtask

  task automatic model_edge(input bit s, input bit p);
    bit se, pe;
    se = s && !m_prev_s;
    pe = p && !m_prev_p;
    m_prev_s = s;
    m_prev_p = p;
    m_done = 0;
    if (m_run) begin
      if (pe) begin
        m_elapsed = ms_at(cyc);
        m_live    = ms_at(cyc);
        m_ovf     = over_at(cyc);
        m_done    = 1;
        m_run     = 0;
      end else if (se) begin
        m_t0 = cyc;
      end
    end else if (se) begin
      m_run = 1;
      m_t0  = cyc;
    end
    if (m_run) begin
      m_live = ms_at(cyc);
      m_ovf  = over_at(cyc);
    end
  endtask

  task automatic compare_all();
    check("busy",       32'(bus.busy),       32'(m_run));
    check("done",       32'(bus.done),       32'(m_done));
    check("overflow",   32'(bus.overflow),   32'(m_ovf));
    check("live_ms",    32'(bus.live_ms),    32'(m_live));
    check("elapsed_ms", 32'(bus.elapsed_ms), 32'(m_elapsed));
  endtask

  // Called at a negedge: drive inputs, let one active edge happen, compare at the next negedge.
  task automatic step(input bit s, input bit p);
    bus.start = s;
    bus.stop  = p;
    @(posedge clk);
    cyc++;
    model_edge(s, p);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic apply_reset(input int unsigned n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  // Start edge, n-1 quiet cycles, stop edge at k+n, then two cycles to see done fall.
  task automatic measure(input int unsigned n);
    step(1'b1, 1'b0);
    idle(n - 1);
    step(1'b0, 1'b1);
    idle(2);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.stop  = 1'b0;
    @(negedge clk);
    apply_reset(3);

    // start held high through reset release: no edge
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    idle(1);

    measure(13);
    measure(12);
    measure(11);
    measure(3);
    measure(4);

    step(1'b0, 1'b1);
    idle(3);

    // restart at n=9, stop 6 cycles later
    step(1'b1, 1'b0);
    idle(8);
    step(1'b1, 1'b0);
    idle(5);
    step(1'b0, 1'b1);
    idle(2);

    // simultaneous start and stop while running
    step(1'b1, 1'b0);
    idle(9);
    step(1'b1, 1'b1);
    idle(4);

    // reset mid-run at n=7, then a clean measurement
    step(1'b1, 1'b0);
    idle(6);
    apply_reset(2);
    idle(2);
    measure(10);

    for (int r = 0; r < 25; r++) begin
      measure($urandom_range(1, 30));
      idle($urandom_range(0, 3));
    end
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);
    step(1'b0, 1'b0);
    idle(3);

    // saturation, then the next start clears overflow
    measure(4 * 65536 + 8);
    step(1'b1, 1'b0);
    idle(5);
    step(1'b0, 1'b1);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/elapsed_ms.md
# elapsed_ms

Millisecond stopwatch: measures the time between a rising edge on `start` and a rising edge on `stop`, in whole milliseconds derived from the system clock. It is the measuring counterpart of the millisecond delay generator. The delay generator produces an N-ms wait; this block reports N for an externally timed interval, for example a button hold or an external device's response time. It sits beside the delay generator on the same clock, and its result is read by control FSMs or display logic.

## Interface
- `PER_MS_COUNTER_VALUE`, default 50_000: clock cycles per millisecond. Change it if the main clock changes. Legal range is 2 to 2^24.
- `clk` input, 1 bit: system clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `start` input, 1 bit: level input. Its rising edge begins a measurement or restarts the current one.
- `stop` input, 1 bit: level input. Its rising edge ends the measurement.
- `busy` output, 1 bit: high while measuring (state RUN).
- `done` output, 1 bit: one-cycle pulse when a new result is latched.
- `overflow` output, 1 bit: set when the last or current measurement saturated.
- `elapsed_ms` output, 16 bits: last completed measurement. Held until the next `done`.
- `live_ms` output, 16 bits: running millisecond count during RUN. Frozen in IDLE.

## Operation
- Edge detect:
  - `start_q` and `stop_q` register the inputs each cycle.
  - `start_edge = start & ~start_q`; `stop_edge = stop & ~stop_q`. Both are combinational.
  - Both registers reset to 1, so a level already high at reset release is not an edge.
- States: IDLE and RUN. The unused encoding goes to IDLE.
- IDLE:
  - `start_edge`: set `sub_cnt`, `live_ms` and `overflow` to 0, then go to RUN.
  - `stop_edge` alone is ignored.
- RUN:
  - Every cycle `sub_cnt` increments. When `sub_cnt == PER_MS_COUNTER_VALUE-1`, it wraps to 0 and `live_ms` increments (the ms tick).
  - At `live_ms == 16'hFFFF`, a tick leaves it at FFFF and sets `overflow`. It never wraps.
  - `stop_edge`:
    - `elapsed_ms` takes the post-tick value of `live_ms`, so a tick on the same edge is counted.
    - `done` is set for one cycle, then go to IDLE.
  - `start_edge` without `stop_edge`: restart. Clear `sub_cnt`, `live_ms` and `overflow`, and stay in RUN with no `done`.
  - `start_edge` and `stop_edge` on the same edge: stop wins and the start is ignored.
- Arithmetic:
  - `sub_cnt` width is `$clog2(PER_MS_COUNTER_VALUE)`. Its compare uses the full width.
  - `live_ms` and `elapsed_ms` are 16-bit unsigned.

## Timing
- Reset values:
  - State is IDLE.
  - `busy`, `done`, `overflow`, `elapsed_ms`, `live_ms` and `sub_cnt` are 0.
  - `start_q` and `stop_q` are 1.
- Reset asserted mid-RUN aborts the measurement: no `done`, and `elapsed_ms` is cleared to 0.
- Start edge sampled at clock edge k means `busy` is high from edge k.
- Stop edge sampled at edge k+n means:
  - `elapsed_ms = min(floor(n / PER_MS_COUNTER_VALUE), 65535)`.
  - `done` is high for exactly the one cycle after edge k+n.
  - `busy` is low from edge k+n.
- The first ms tick comes exactly `PER_MS_COUNTER_VALUE` edges after the start edge. Later ticks follow every `PER_MS_COUNTER_VALUE` edges.
- Minimum re-arm: a new start edge is accepted on the edge after `done` falls. Inputs need at least one low cycle between edges.
- Inputs are assumed synchronous to `clk`. Synchronising asynchronous sources is the caller's job.

## Structure
- The shared timing package holds:
  - the default `PER_MS_COUNTER_VALUE`, also used by the delay generator;
  - the state encoding localparams `ST_IDLE`/`ST_RUN`;
  - the 16-bit ms-count width constant.
- One sub-module, `ms_tick_gen`:
  - a prescaler with inputs `clr` and `en`, output `tick`, and parameter `PER_MS_COUNTER_VALUE`;
  - the delay generator can reuse it.
- Edge detect and the FSM stay in `elapsed_ms`.

## Test plan
Simulation uses `PER_MS_COUNTER_VALUE=4`.
- Reset then idle: `rst_n` low with `start` held high, then released. Required: no edge, `busy=0`, all outputs 0 for 20 cycles.
- Basic measure:
  - stimulus: start edge at cycle 10, stop edge at cycle 23 (n=13);
  - required: `elapsed_ms=3`, `done` high only at cycle 24, `busy` high for cycles 10–22.
- Boundary: stop at n=12 gives 3 (tick on the same edge is counted); n=11 gives 2; n=3 gives 0 with `done` still pulsed.
- Restart and simultaneity:
  - second start edge at n=9 with stop 6 cycles later: required `elapsed_ms=1`;
  - start and stop on the same edge in RUN: treated as stop, then IDLE.
- Saturation: stop at n=4*65536+8. Required: `elapsed_ms=65535`, `overflow=1`. The next start clears `overflow`.
- Reset mid-RUN: `rst_n` pulsed low at n=7. Required: no `done`, `elapsed_ms=0`, IDLE, and a following measurement is correct.
